// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM bus: pipeline latch inputs, data-cache handshake, and MEM/WB drive.
interface mem_stage_if;
  // EX/MEM latch contents
  logic        exmem_valid;
  logic        exmem_dREN;
  logic        exmem_dWEN;
  logic [5:0]  exmem_op;
  logic [31:0] exmem_addr;
  logic [31:0] exmem_store;
  logic        exmem_halt;
  // data cache response and coherence invalidate
  logic        dhit;
  logic [31:0] dmemload;
  logic        linkinv;
  logic [31:0] linkinvaddr;
  // data cache request
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  // pipeline control and MEM/WB drive
  logic        mem_stall;
  logic        memwb_enable;
  logic [31:0] dmemload_out;
  logic        halt_out;

  // pipeline/cache side
  modport master (
    output exmem_valid, exmem_dREN, exmem_dWEN, exmem_op, exmem_addr, exmem_store,
           exmem_halt, dhit, dmemload, linkinv, linkinvaddr,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, memwb_enable,
           dmemload_out, halt_out
  );

  // memory stage side
  modport slave (
    input  exmem_valid, exmem_dREN, exmem_dWEN, exmem_op, exmem_addr, exmem_store,
           exmem_halt, dhit, dmemload, linkinv, linkinvaddr,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, memwb_enable,
           dmemload_out, halt_out
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: data-cache sequencing, LL/SC link tracking and sticky halt.
package cpu_types_pkg;
  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    ADDI  = 6'b001000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000,
    HALT  = 6'b111111
  } opcode_t;
endpackage

module mem_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  mem_stage_if.slave  bus
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   store_q, store_d;
  logic [W-1:0]   load_q, load_d;
  logic [W-1:0]   link_addr_q, link_addr_d;
  logic           wr_q, wr_d;
  logic           ll_q, ll_d;
  logic           sc_q, sc_d;
  logic           link_valid_q, link_valid_d;
  logic           halt_q, halt_d;

  opcode_t        op_c;
  logic           is_mem_c;
  logic           is_sc_c;
  logic           sc_ok_c;
  logic           ren_c, wen_c, stall_c, wb_en_c;

  // Decode of the EX/MEM instruction and SC link check against the live invalidate
  always_comb begin
    op_c     = opcode_t'(bus.exmem_op);
    is_mem_c = bus.exmem_dREN | bus.exmem_dWEN;
    is_sc_c  = bus.exmem_dWEN && (op_c == SC);
    sc_ok_c  = link_valid_q && (link_addr_q == bus.exmem_addr) &&
               !(bus.linkinv && (bus.linkinvaddr == bus.exmem_addr));
  end

  // Next-state, link bookkeeping and combinational handshake outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_d      = store_q;
    load_d       = load_q;
    wr_d         = wr_q;
    ll_d         = ll_q;
    sc_d         = sc_q;
    halt_d       = halt_q;
    link_addr_d  = link_addr_q;
    // a snooped write to the linked word kills the reservation; LL completion below may re-set it
    link_valid_d = link_valid_q && !(bus.linkinv && (bus.linkinvaddr == link_addr_q));
    ren_c        = 1'b0;
    wen_c        = 1'b0;
    stall_c      = 1'b0;
    wb_en_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exmem_valid) begin
          if (bus.exmem_halt) begin
            // halt wins over any memory flags that arrive alongside it
            wb_en_c = 1'b1;
            halt_d  = 1'b1;
            state_d = HALTED;
          end else if (is_sc_c && !sc_ok_c) begin
            // failed SC retires immediately with a zero result and no cache traffic
            wb_en_c      = 1'b1;
            load_d       = '0;
            link_valid_d = 1'b0;
          end else if (is_mem_c) begin
            addr_d  = bus.exmem_addr;
            store_d = bus.exmem_store;
            wr_d    = bus.exmem_dWEN;
            ll_d    = !bus.exmem_dWEN && (op_c == LL);
            sc_d    = is_sc_c;
            stall_c = 1'b1;
            state_d = REQ;
          end else begin
            wb_en_c = 1'b1;
          end
        end
      end

      REQ: begin
        ren_c = !wr_q;
        wen_c = wr_q;
        if (bus.dhit) begin
          wb_en_c = 1'b1;
          state_d = IDLE;
          if (!wr_q) begin
            load_d = bus.dmemload;
          end
          if (ll_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_q;
          end
          if (sc_q) begin
            load_d       = W'(1);
            link_valid_d = 1'b0;
          end else if (wr_q && (addr_q == link_addr_q)) begin
            link_valid_d = 1'b0;
          end
        end else begin
          stall_c = 1'b1;
        end
      end

      HALTED: begin
        halt_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_q      <= '0;
      load_q       <= '0;
      wr_q         <= 1'b0;
      ll_q         <= 1'b0;
      sc_q         <= 1'b0;
      halt_q       <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      load_q       <= load_d;
      wr_q         <= wr_d;
      ll_q         <= ll_d;
      sc_q         <= sc_d;
      halt_q       <= halt_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  // A reset cycle never lets MEM/WB capture an abandoned access
  assign bus.dmemREN      = ren_c;
  assign bus.dmemWEN      = wen_c;
  assign bus.dmemaddr     = addr_q;
  assign bus.dmemstore    = store_q;
  assign bus.mem_stall    = stall_c;
  assign bus.memwb_enable = wb_en_c && !RST;
  assign bus.dmemload_out = load_q;
  assign bus.halt_out     = halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expectations, a negedge monitor retires them.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_stage_if bus ();
  mem_stage dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [31:0] load;
    logic        halt;
  } wb_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } rq_t;

  wb_t  wb_q[$];
  rq_t  rq_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: retire a writeback the cycle after memwb_enable, and a cache request on its hit
  always @(negedge CLK) begin
    wb_t w;
    rq_t r;
    if (pending) begin
      if (wb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got memwb_enable expected none (t=%0t)", $time);
      end else begin
        w = wb_q.pop_front();
        chk("wb_load", bus.dmemload_out, w.load);
        chk("wb_halt", 32'(bus.halt_out), 32'(w.halt));
      end
    end
    pending = bus.memwb_enable;
    if (bus.dhit && (bus.dmemREN || bus.dmemWEN)) begin
      if (rq_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rq_unexpected: got request expected none (t=%0t)", $time);
      end else begin
        r = rq_q.pop_front();
        chk("rq_ren", 32'(bus.dmemREN), 32'(!r.wen));
        chk("rq_wen", 32'(bus.dmemWEN), 32'(r.wen));
        chk("rq_addr", bus.dmemaddr, r.addr);
        chk("rq_store", bus.dmemstore, r.store);
      end
    end
  end

  task automatic clear_inputs();
    bus.exmem_valid = 1'b0;
    bus.exmem_dREN  = 1'b0;
    bus.exmem_dWEN  = 1'b0;
    bus.exmem_op    = 6'(RTYPE);
    bus.exmem_addr  = '0;
    bus.exmem_store = '0;
    bus.exmem_halt  = 1'b0;
    bus.dhit        = 1'b0;
    bus.dmemload    = '0;
    bus.linkinv     = 1'b0;
    bus.linkinvaddr = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic inv, input logic [31:0] inv_addr);
    for (int i = 0; i < n; i++) begin
      bus.linkinv     = inv;
      bus.linkinvaddr = inv_addr;
      step();
    end
    bus.linkinv = 1'b0;
  endtask

  task automatic nonmem(input logic [31:0] exp_out);
    bus.exmem_valid = 1'b1;
    bus.exmem_op    = 6'(ADDI);
    bus.exmem_addr  = 32'h0000_0ABC;
    wb_q.push_back(wb_t'{exp_out, 1'b0});
    @(negedge CLK);
    chk("nonmem_stall", 32'(bus.mem_stall), 32'd0);
    chk("nonmem_req", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
    step();
    clear_inputs();
  endtask

  // One memory instruction; ok=0 is a failing SC that must retire without a request.
  // inv_cyc picks the cycle (0 = accept) on which linkinv for inv_addr is raised.
  task automatic mem_op(input opcode_t op, input logic [31:0] addr, input logic [31:0] store,
                        input logic [31:0] rdata, input int waits, input logic ok,
                        input logic [31:0] exp_out, input int inv_cyc, input logic [31:0] inv_addr);
    logic wr;
    int   n, stalls, reqs;
    wr     = (op == SW) || (op == SC);
    stalls = 0;
    reqs   = 0;
    n      = ok ? waits + 2 : 1;
    bus.exmem_valid = 1'b1;
    bus.exmem_op    = 6'(op);
    bus.exmem_dREN  = !wr;
    bus.exmem_dWEN  = wr;
    bus.exmem_addr  = addr;
    bus.exmem_store = store;
    if (ok) rq_q.push_back(rq_t'{wr, addr, store});
    wb_q.push_back(wb_t'{exp_out, 1'b0});
    for (int c = 0; c < n; c++) begin
      bus.dhit        = ok && (c == n - 1);
      bus.dmemload    = bus.dhit ? rdata : 32'hBAD0_BAD0;
      bus.linkinv     = (c == inv_cyc);
      bus.linkinvaddr = inv_addr;
      @(negedge CLK);
      stalls += int'(bus.mem_stall);
      reqs   += int'(bus.dmemREN | bus.dmemWEN);
      if (c == 0) chk("accept_wb_en", 32'(bus.memwb_enable), 32'(!ok));
      step();
    end
    chk("stall_cycles", 32'(stalls), ok ? 32'(waits + 1) : 32'd0);
    chk("req_cycles", 32'(reqs), ok ? 32'(waits + 1) : 32'd0);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_stall", 32'(bus.mem_stall), 32'd0);
    chk("rst_wb_en", 32'(bus.memwb_enable), 32'd0);
    chk("rst_req", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
    chk("rst_load_out", bus.dmemload_out, 32'd0);
    chk("rst_halt", 32'(bus.halt_out), 32'd0);
    chk("rst_addr", bus.dmemaddr, 32'd0);
    step();

    // plain ALU op and loads
    nonmem(32'd0);
    mem_op(LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF, -1, 32'h0);
    mem_op(LW, 32'h104, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h1234_5678, -1, 32'h0);
    nonmem(32'h1234_5678);
    mem_op(SW, 32'h300, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 32'h1234_5678, -1, 32'h0);

    // LL then SC succeeds once, second SC fails
    mem_op(LL, 32'h200, 32'h0, 32'hAAAA_5555, 1, 1'b1, 32'hAAAA_5555, -1, 32'h0);
    mem_op(SC, 32'h200, 32'h5, 32'h0, 2, 1'b1, 32'd1, -1, 32'h0);
    mem_op(SC, 32'h200, 32'h6, 32'h0, 0, 1'b0, 32'd0, -1, 32'h0);

    // invalidate of the linked word kills the SC
    mem_op(LL, 32'h200, 32'h0, 32'h11, 0, 1'b1, 32'h11, -1, 32'h0);
    idle(1, 1'b1, 32'h200);
    mem_op(SC, 32'h200, 32'h7, 32'h0, 0, 1'b0, 32'd0, -1, 32'h0);

    // invalidate of another word leaves the link
    mem_op(LL, 32'h200, 32'h0, 32'h22, 0, 1'b1, 32'h22, -1, 32'h0);
    idle(1, 1'b1, 32'h204);
    mem_op(SC, 32'h200, 32'h7, 32'h0, 0, 1'b1, 32'd1, -1, 32'h0);

    // LL completion beats a same-cycle invalidate
    mem_op(LL, 32'h200, 32'h0, 32'h33, 1, 1'b1, 32'h33, 2, 32'h200);
    mem_op(SC, 32'h200, 32'h5, 32'h0, 0, 1'b1, 32'd1, -1, 32'h0);

    // SW to the linked word clears the link; SW elsewhere does not
    mem_op(LL, 32'h200, 32'h0, 32'h44, 0, 1'b1, 32'h44, -1, 32'h0);
    mem_op(SW, 32'h200, 32'h9, 32'h0, 0, 1'b1, 32'h44, -1, 32'h0);
    mem_op(SC, 32'h200, 32'h8, 32'h0, 0, 1'b0, 32'd0, -1, 32'h0);
    mem_op(LL, 32'h200, 32'h0, 32'h55, 0, 1'b1, 32'h55, -1, 32'h0);
    mem_op(SW, 32'h208, 32'h9, 32'h0, 0, 1'b1, 32'h55, -1, 32'h0);
    mem_op(SC, 32'h200, 32'h8, 32'h0, 0, 1'b1, 32'd1, -1, 32'h0);

    // invalidate arriving with the SC itself
    mem_op(LL, 32'h200, 32'h0, 32'h88, 0, 1'b1, 32'h88, -1, 32'h0);
    mem_op(SC, 32'h200, 32'h8, 32'h0, 0, 1'b0, 32'd0, 0, 32'h200);

    // reset in the middle of a store request, with dhit in the reset cycle
    mem_op(LL, 32'h200, 32'h0, 32'h66, 0, 1'b1, 32'h66, -1, 32'h0);
    bus.exmem_valid = 1'b1;
    bus.exmem_op    = 6'(SW);
    bus.exmem_dWEN  = 1'b1;
    bus.exmem_addr  = 32'h400;
    bus.exmem_store = 32'h77;
    rq_q.push_back(rq_t'{1'b1, 32'h400, 32'h77});
    step();
    step();
    RST      = 1'b1;
    bus.dhit = 1'b1;
    @(negedge CLK);
    chk("rst_mid_wb_en", 32'(bus.memwb_enable), 32'd0);
    step();
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    chk("post_rst_wen", 32'(bus.dmemWEN | bus.dmemREN), 32'd0);
    chk("post_rst_wb_en", 32'(bus.memwb_enable), 32'd0);
    chk("post_rst_load_out", bus.dmemload_out, 32'd0);
    chk("post_rst_addr", bus.dmemaddr, 32'd0);
    chk("post_rst_store", bus.dmemstore, 32'd0);
    step();
    mem_op(SC, 32'h200, 32'h1, 32'h0, 0, 1'b0, 32'd0, -1, 32'h0);

    // halt with a load flag alongside: halt wins, then the stage is frozen
    bus.exmem_valid = 1'b1;
    bus.exmem_op    = 6'(LW);
    bus.exmem_dREN  = 1'b1;
    bus.exmem_addr  = 32'h500;
    bus.exmem_halt  = 1'b1;
    wb_q.push_back(wb_t'{32'd0, 1'b1});
    @(negedge CLK);
    chk("halt_wb_en", 32'(bus.memwb_enable), 32'd1);
    chk("halt_req", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
    chk("halt_stall", 32'(bus.mem_stall), 32'd0);
    step();
    clear_inputs();
    step();
    bus.exmem_valid = 1'b1;
    bus.exmem_op    = 6'(LW);
    bus.exmem_dREN  = 1'b1;
    bus.exmem_addr  = 32'h600;
    for (int i = 0; i < 3; i++) begin
      bus.dhit = i[0];
      @(negedge CLK);
      chk("halted_req", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
      chk("halted_wb_en", 32'(bus.memwb_enable), 32'd0);
      chk("halted_stall", 32'(bus.mem_stall), 32'd0);
      chk("halted_halt", 32'(bus.halt_out), 32'd1);
      step();
    end
    clear_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("unhalt_halt", 32'(bus.halt_out), 32'd0);
    step();

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("rq_queue_drained", 32'(rq_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
